// File: rtl/ps2_host_pkg.sv
// Shared types and defaults for the PS/2 host-to-device transmit path.
package ps2_host_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        WAIT_START,
        SHIFT,
        WAIT_IDLE,
        FAIL
    } state_t;

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_START = 2'b01;
    localparam logic [1:0] ERR_BIT   = 2'b10;
    localparam logic [1:0] ERR_NOACK = 2'b11;

    localparam int TIMER_W = 20;

    // 50 MHz defaults: 120 us inhibit, 2 us request, 15 ms start window, 2 ms per bit
    localparam int DEF_INHIBIT_CYCLES = 6000;
    localparam int DEF_REQ_CYCLES     = 100;
    localparam int DEF_START_TIMEOUT  = 750000;
    localparam int DEF_BIT_TIMEOUT    = 100000;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// 2-FF synchronizer for a raw PS/2 pin with a one-cycle falling-edge flag.
// Edge flag appears two clocks after the pin change; no backpressure.
module ps2_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic pin,
    output logic level,
    output logic fall
);

    logic meta;
    logic sync;
    logic prev;

    // Idle PS/2 lines float high, so reset to 1 avoids a false edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= 1'b1;
            sync <= 1'b1;
            prev <= 1'b1;
        end else begin
            meta <= pin;
            sync <= meta;
            prev <= sync;
        end
    end

    assign level = sync;
    assign fall  = prev & ~sync;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command sender: inhibit, request-to-send, clocked-out frame, ack check.
// Accepts one byte only in IDLE (cmd_ready); transfer time is set by the device clock.
module ps2_host_tx
    import ps2_host_pkg::*;
#(
    parameter int INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
    parameter int REQ_CYCLES     = DEF_REQ_CYCLES,
    parameter int START_TIMEOUT  = DEF_START_TIMEOUT,
    parameter int BIT_TIMEOUT    = DEF_BIT_TIMEOUT
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [7:0] cmd_data,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [1:0] err_code
);

    localparam logic [TIMER_W-1:0] INH_LAST   = TIMER_W'(INHIBIT_CYCLES - 1);
    localparam logic [TIMER_W-1:0] REQ_LAST   = TIMER_W'(REQ_CYCLES - 1);
    localparam logic [TIMER_W-1:0] START_LAST = TIMER_W'(START_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] BIT_LAST   = TIMER_W'(BIT_TIMEOUT - 1);

    state_t               state, state_nxt;
    logic [TIMER_W-1:0]   timer, timer_nxt;
    logic [7:0]           sr, sr_nxt;
    logic                 parity, parity_nxt;
    logic [3:0]           bitcnt, bitcnt_nxt;
    logic                 dat_drive, dat_drive_nxt;
    logic [1:0]           err_q, err_nxt;
    logic                 done_q;

    logic clk_level;
    logic clk_fall;
    logic dat_level;
    logic dat_fall_unused;

    ps2_sync_edge u_clk_sync (
        .clk   (CLOCK_50),
        .reset (reset),
        .pin   (ps2_clk_in),
        .level (clk_level),
        .fall  (clk_fall)
    );

    ps2_sync_edge u_dat_sync (
        .clk   (CLOCK_50),
        .reset (reset),
        .pin   (ps2_dat_in),
        .level (dat_level),
        .fall  (dat_fall_unused)
    );

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state     <= IDLE;
            timer     <= '0;
            sr        <= '0;
            parity    <= 1'b0;
            bitcnt    <= '0;
            dat_drive <= 1'b0;
            err_q     <= ERR_NONE;
            done_q    <= 1'b0;
        end else begin
            state     <= state_nxt;
            timer     <= timer_nxt;
            sr        <= sr_nxt;
            parity    <= parity_nxt;
            bitcnt    <= bitcnt_nxt;
            dat_drive <= dat_drive_nxt;
            err_q     <= err_nxt;
            done_q    <= (state == WAIT_IDLE) && (state_nxt == IDLE);
        end
    end

    always_comb begin
        state_nxt     = state;
        timer_nxt     = timer + TIMER_W'(1);
        sr_nxt        = sr;
        parity_nxt    = parity;
        bitcnt_nxt    = bitcnt;
        dat_drive_nxt = dat_drive;
        err_nxt       = err_q;

        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    sr_nxt        = cmd_data;
                    parity_nxt    = odd_parity(cmd_data);
                    err_nxt       = ERR_NONE;
                    bitcnt_nxt    = '0;
                    dat_drive_nxt = 1'b0;
                    state_nxt     = INHIBIT;
                end
            end
            INHIBIT: begin
                if (timer == INH_LAST) state_nxt = REQ;
            end
            REQ: begin
                if (timer == REQ_LAST) state_nxt = WAIT_START;
            end
            WAIT_START: begin
                if (clk_fall) begin
                    dat_drive_nxt = ~sr[0];
                    bitcnt_nxt    = 4'd1;
                    state_nxt     = SHIFT;
                end else if (timer == START_LAST) begin
                    err_nxt   = ERR_START;
                    state_nxt = FAIL;
                end
            end
            SHIFT: begin
                // New data is registered off the edge flag, so it moves while the device holds clock low.
                if (clk_fall) begin
                    timer_nxt  = '0;
                    bitcnt_nxt = bitcnt + 4'd1;
                    if (bitcnt < 4'd8) begin
                        dat_drive_nxt = ~sr[bitcnt[2:0]];
                    end else if (bitcnt == 4'd8) begin
                        dat_drive_nxt = ~parity;
                    end else if (bitcnt == 4'd9) begin
                        dat_drive_nxt = 1'b0;
                    end else if (!dat_level) begin
                        state_nxt = WAIT_IDLE;
                    end else begin
                        err_nxt   = ERR_NOACK;
                        state_nxt = FAIL;
                    end
                end else if (timer == BIT_LAST) begin
                    err_nxt   = ERR_BIT;
                    state_nxt = FAIL;
                end
            end
            WAIT_IDLE: begin
                if (clk_level && dat_level) begin
                    state_nxt = IDLE;
                end else if (timer == BIT_LAST) begin
                    err_nxt   = ERR_BIT;
                    state_nxt = FAIL;
                end
            end
            FAIL: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (state_nxt != state) timer_nxt = '0;
    end

    assign cmd_ready  = (state == IDLE);
    assign busy       = (state != IDLE);
    assign ps2_clk_oe = (state == INHIBIT) || (state == REQ);
    assign ps2_dat_oe = (state == REQ) || (state == WAIT_START) || ((state == SHIFT) && dat_drive);
    assign done       = done_q;
    assign error      = (state == FAIL);
    assign err_code   = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-drain PS/2 device model and a result scoreboard.
module tb_ps2_host_tx;

    localparam int INH  = 60;
    localparam int RQ   = 10;
    localparam int STO  = 2000;
    localparam int BTO  = 500;
    localparam int HALF = 40;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] cmd_data;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       ps2_clk_in;
    logic       ps2_dat_in;
    logic       ps2_clk_oe;
    logic       ps2_dat_oe;
    logic       busy;
    logic       done;
    logic       error;
    logic [1:0] err_code;

    logic dev_clk_low = 1'b0;
    logic dev_dat_low = 1'b0;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    int err_cyc  = 0;
    int last_fall_cyc = 0;
    logic [1:0] last_code    = 2'b00;
    logic [1:0] code_at_done = 2'b00;
    logic       busy_at_done = 1'b0;
    logic [1:0] oe_at_err    = 2'b00;

    logic [10:0] exp_frame_q[$];
    logic [2:0]  exp_res_q[$];

    always #5 clk = ~clk;

    assign ps2_clk_in = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_dat_in = ~(ps2_dat_oe | dev_dat_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .REQ_CYCLES     (RQ),
        .START_TIMEOUT  (STO),
        .BIT_TIMEOUT    (BTO)
    ) dut (
        .CLOCK_50   (clk),
        .reset      (reset),
        .cmd_data   (cmd_data),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .ps2_clk_in (ps2_clk_in),
        .ps2_dat_in (ps2_dat_in),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_dat_oe (ps2_dat_oe),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .err_code   (err_code)
    );

    // Pulse monitor: done/error are single-cycle and may fire while the device model is busy.
    always @(negedge clk) begin
        cyc++;
        if (done === 1'b1) begin
            done_cnt++;
            busy_at_done = busy;
            code_at_done = err_code;
        end
        if (error === 1'b1) begin
            err_cnt++;
            err_cyc   = cyc;
            last_code = err_code;
            oe_at_err = {ps2_clk_oe, ps2_dat_oe};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    task automatic send(input logic [7:0] d, input bit poke);
        int n;
        chk("ready_before_send", 32'(cmd_ready), 32'd1);
        exp_frame_q.push_back({1'b1, ~^d, d, 1'b0});
        cmd_data  = d;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        n = 0;
        while (ps2_clk_oe === 1'b1 && ps2_dat_oe === 1'b0 && n < INH + 50) begin
            cmd_valid = (poke && n == 3);
            if (poke && n == 3) cmd_data = 8'h55;
            tick();
            n++;
        end
        cmd_valid = 1'b0;
        chk("inhibit_len", n, INH);
        n = 0;
        while (ps2_clk_oe === 1'b1 && ps2_dat_oe === 1'b1 && n < RQ + 50) begin
            tick();
            n++;
        end
        chk("req_len", n, RQ);
        chk("release_start_held", {30'd0, ps2_clk_oe, ps2_dat_oe}, 32'b01);
    endtask

    task automatic device(input int edges, input bit ack, input bit do_check);
        logic [10:0] got;
        logic [10:0] want;
        got    = '0;
        got[0] = ps2_dat_in;
        repeat (20) tick();
        for (int e = 0; e < edges; e++) begin
            if (e == 10 && ack) begin
                dev_dat_low = 1'b1;
                repeat (5) tick();
            end
            dev_clk_low   = 1'b1;
            last_fall_cyc = cyc;
            repeat (HALF) tick();
            dev_clk_low = 1'b0;
            if (e < 10) got[e+1] = ps2_dat_in;
            repeat (HALF) tick();
            if (e == 10) dev_dat_low = 1'b0;
        end
        want = exp_frame_q.pop_front();
        if (do_check) chk("frame", 32'(got), 32'(want));
    endtask

    task automatic wait_result(input int base_done, input int base_err);
        int n;
        logic [2:0] want;
        logic [2:0] got;
        n = 0;
        while (done_cnt == base_done && err_cnt == base_err && n < STO + BTO) begin
            tick();
            n++;
        end
        repeat (20) tick();
        want = exp_res_q.pop_front();
        got  = (err_cnt != base_err) ? {1'b1, last_code} : {1'b0, code_at_done};
        chk("result", 32'(got), 32'(want));
        chk("pulse_count", (done_cnt - base_done) + (err_cnt - base_err), 1);
        chk("idle_after", {28'd0, busy, cmd_ready, ps2_clk_oe, ps2_dat_oe}, 32'b0100);
    endtask

    initial begin
        int bd;
        int be;
        int n;
        logic [7:0] small_bytes [2];

        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_data  = 8'h00;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        chk("rst_ready",  32'(cmd_ready),  32'd1);
        chk("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
        chk("rst_dat_oe", 32'(ps2_dat_oe), 32'd0);
        chk("rst_busy",   32'(busy),       32'd0);
        chk("rst_done",   32'(done),       32'd0);
        chk("rst_error",  32'(error),      32'd0);
        chk("rst_code",   32'(err_code),   32'd0);

        // Set-LEDs command, full acknowledged transfer
        bd = done_cnt; be = err_cnt;
        send(8'hED, 1'b0);
        exp_res_q.push_back({1'b0, 2'b00});
        device(11, 1'b1, 1'b1);
        wait_result(bd, be);
        chk("ed_busy_at_done", 32'(busy_at_done), 32'd0);

        small_bytes[0] = 8'h01;
        small_bytes[1] = 8'h00;
        foreach (small_bytes[i]) begin
            bd = done_cnt; be = err_cnt;
            send(small_bytes[i], 1'b0);
            exp_res_q.push_back({1'b0, 2'b00});
            device(11, 1'b1, 1'b1);
            wait_result(bd, be);
        end

        // Silent device: start timeout measured from clock release
        bd = done_cnt; be = err_cnt;
        send(8'h77, 1'b0);
        void'(exp_frame_q.pop_front());
        n = 0;
        while (error !== 1'b1 && n < STO + 100) begin
            tick();
            n++;
        end
        chk("start_timeout_len", n, STO);
        chk("start_timeout_code", 32'(err_code), 32'd1);
        chk("start_timeout_oe", {30'd0, ps2_clk_oe, ps2_dat_oe}, 32'd0);
        exp_res_q.push_back({1'b1, 2'b01});
        wait_result(bd, be);

        // Device stalls after 4 falling edges
        bd = done_cnt; be = err_cnt;
        send(8'h3C, 1'b0);
        exp_res_q.push_back({1'b1, 2'b10});
        device(4, 1'b0, 1'b0);
        wait_result(bd, be);
        chk("bit_timeout_len", err_cyc - last_fall_cyc, BTO + 4);
        chk("bit_timeout_oe", 32'(oe_at_err), 32'd0);

        // Full clocking but no ack
        bd = done_cnt; be = err_cnt;
        send(8'h5A, 1'b0);
        exp_res_q.push_back({1'b1, 2'b11});
        device(11, 1'b0, 1'b1);
        wait_result(bd, be);

        // Reset while bit 5 is on the line
        bd = done_cnt; be = err_cnt;
        send(8'hA5, 1'b0);
        device(6, 1'b0, 1'b0);
        chk("busy_in_shift", 32'(busy), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_oe", {30'd0, ps2_clk_oe, ps2_dat_oe}, 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_ready", 32'(cmd_ready), 32'd1);
        repeat (20) tick();
        chk("abort_no_pulse", (done_cnt - bd) + (err_cnt - be), 0);

        // Fresh command after abort, with a stray request while busy
        bd = done_cnt; be = err_cnt;
        send(8'hF4, 1'b1);
        exp_res_q.push_back({1'b0, 2'b00});
        device(11, 1'b1, 1'b1);
        wait_result(bd, be);
        n = 0;
        for (int k = 0; k < 100; k++) begin
            if (busy === 1'b1 || ps2_clk_oe === 1'b1) n++;
            tick();
        end
        chk("no_second_transfer", n, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
